control_unit: RTL and testbench

- Multicycle control FSM that drives every control and mux-select input of the CPU datapath, and reads back the instruction fields and ALU flags.
- It is the producer side of the datapath's control interface.
- It sequences fetch, decode, execute, memory and writeback for an R/I/J MIPS subset: add, sub, and, addi, lw, sw, beq, bne, j.
- It handles two exceptions: invalid opcode/funct and arithmetic overflow.

---
 rtl/cpu_ctrl_pkg.sv | 74 +++++++
 rtl/control_unit.sv | 175 +++++++++++++++++
 tb/tb_control_unit.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - state, opcode/funct, ALU and mux-select encodings for the multicycle control unit
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RESET,
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_WB_R,
    S_WB_I,
    S_MEM_ADDR,
    S_LW_READ,
    S_LW_WB,
    S_SW_WRITE,
    S_BRANCH,
    S_JUMP,
    S_EXC
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;

  localparam logic [2:0] ULA_NONE = 3'b000;
  localparam logic [2:0] ULA_ADD  = 3'b001;
  localparam logic [2:0] ULA_SUB  = 3'b010;
  localparam logic [2:0] ULA_AND  = 3'b011;
  localparam logic [2:0] ULA_CMP  = 3'b111;

  localparam logic [1:0] WR_RT = 2'b00;
  localparam logic [1:0] WR_RD = 2'b01;

  localparam logic [2:0] WD_ALUOUT = 3'b000;
  localparam logic [2:0] WD_MEM    = 3'b001;

  localparam logic       SA_PC = 1'b0;
  localparam logic       SA_A  = 1'b1;

  localparam logic [1:0] SB_B       = 2'b00;
  localparam logic [1:0] SB_FOUR    = 2'b01;
  localparam logic [1:0] SB_SEXT    = 2'b10;
  localparam logic [1:0] SB_SEXT_SH = 2'b11;

  localparam logic [2:0] PCS_RESULT = 3'b000;
  localparam logic [2:0] PCS_ALUOUT = 3'b001;
  localparam logic [2:0] PCS_JUMP   = 3'b010;
  localparam logic [2:0] PCS_EXC    = 3'b100;

  localparam logic [2:0] MA_PC     = 3'b000;
  localparam logic [2:0] MA_ALUOUT = 3'b001;

  function automatic logic r_funct_valid(input logic [5:0] funct);
    return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND);
  endfunction

  function automatic logic [2:0] funct_to_ula(input logic [5:0] funct);
    case (funct)
      FN_ADD:  return ULA_ADD;
      FN_SUB:  return ULA_SUB;
      FN_AND:  return ULA_AND;
      default: return ULA_NONE;
    endcase
  endfunction

endpackage

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multicycle MIPS-subset control FSM with memory wait counter
module control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OPCODE,
  input  logic [5:0] FUNCT,
  input  logic       Of,
  input  logic       Eq,
  output logic       PC_w,
  output logic       MEM_w,
  output logic       IR_w,
  output logic       RB_w,
  output logic       AB_w,
  output logic       ALU_w,
  output logic       EPC_w,
  output logic [2:0] ULA_c,
  output logic [1:0] M_selector_writereg,
  output logic [2:0] M_selector_WDATA,
  output logic       M_selector_A,
  output logic [1:0] M_selector_B,
  output logic [2:0] M_selector_ALUOut,
  output logic [2:0] M_selector_Memory
);

  localparam int CW = (MEM_WAIT < 2) ? 1 : $clog2(MEM_WAIT + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(MEM_WAIT);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic          cnt_last;

  assign cnt_last = (cnt == WAIT_MAX);

  // Counter restarts on every state change so each wait state sees 0..MEM_WAIT
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_RESET;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state_next != state)
        cnt <= '0;
      else if (!cnt_last)
        cnt <= cnt + CW'(1);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_RESET:  state_next = S_FETCH;
      S_FETCH:  state_next = cnt_last ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (OPCODE)
          OP_R:          state_next = r_funct_valid(FUNCT) ? S_EXEC_R : S_EXC;
          OP_ADDI:       state_next = S_EXEC_I;
          OP_LW, OP_SW:  state_next = S_MEM_ADDR;
          OP_BEQ, OP_BNE: state_next = S_BRANCH;
          OP_J:          state_next = S_JUMP;
          default:       state_next = S_EXC;
        endcase
      end
      // AND cannot overflow, so only add/sub divert to the exception path
      S_EXEC_R:   state_next = (Of && (FUNCT != FN_AND)) ? S_EXC : S_WB_R;
      S_EXEC_I:   state_next = Of ? S_EXC : S_WB_I;
      S_WB_R:     state_next = S_FETCH;
      S_WB_I:     state_next = S_FETCH;
      S_MEM_ADDR: state_next = (OPCODE == OP_LW) ? S_LW_READ : S_SW_WRITE;
      S_LW_READ:  state_next = cnt_last ? S_LW_WB : S_LW_READ;
      S_LW_WB:    state_next = S_FETCH;
      S_SW_WRITE: state_next = S_FETCH;
      S_BRANCH:   state_next = S_FETCH;
      S_JUMP:     state_next = S_FETCH;
      S_EXC:      state_next = S_FETCH;
      default:    state_next = S_RESET;
    endcase
  end

  always_comb begin
    PC_w                = 1'b0;
    MEM_w               = 1'b0;
    IR_w                = 1'b0;
    RB_w                = 1'b0;
    AB_w                = 1'b0;
    ALU_w               = 1'b0;
    EPC_w               = 1'b0;
    ULA_c               = ULA_NONE;
    M_selector_writereg = WR_RT;
    M_selector_WDATA    = WD_ALUOUT;
    M_selector_A        = SA_PC;
    M_selector_B        = SB_B;
    M_selector_ALUOut   = PCS_RESULT;
    M_selector_Memory   = MA_PC;
    case (state)
      S_FETCH: begin
        M_selector_Memory = MA_PC;
        if (cnt_last) begin
          IR_w              = 1'b1;
          PC_w              = 1'b1;
          M_selector_A      = SA_PC;
          M_selector_B      = SB_FOUR;
          ULA_c             = ULA_ADD;
          M_selector_ALUOut = PCS_RESULT;
        end
      end
      S_DECODE: begin
        AB_w         = 1'b1;
        ALU_w        = 1'b1;
        M_selector_A = SA_PC;
        M_selector_B = SB_SEXT_SH;
        ULA_c        = ULA_ADD;
      end
      S_EXEC_R: begin
        M_selector_A = SA_A;
        M_selector_B = SB_B;
        ULA_c        = funct_to_ula(FUNCT);
        ALU_w        = 1'b1;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        M_selector_A = SA_A;
        M_selector_B = SB_SEXT;
        ULA_c        = ULA_ADD;
        ALU_w        = 1'b1;
      end
      S_WB_R: begin
        RB_w                = 1'b1;
        M_selector_WDATA    = WD_ALUOUT;
        M_selector_writereg = WR_RD;
      end
      S_WB_I: begin
        RB_w                = 1'b1;
        M_selector_WDATA    = WD_ALUOUT;
        M_selector_writereg = WR_RT;
      end
      S_LW_READ: M_selector_Memory = MA_ALUOUT;
      S_LW_WB: begin
        M_selector_Memory   = MA_ALUOUT;
        RB_w                = 1'b1;
        M_selector_WDATA    = WD_MEM;
        M_selector_writereg = WR_RT;
      end
      S_SW_WRITE: begin
        M_selector_Memory = MA_ALUOUT;
        MEM_w             = 1'b1;
      end
      S_BRANCH: begin
        M_selector_A      = SA_A;
        M_selector_B      = SB_B;
        ULA_c             = ULA_CMP;
        M_selector_ALUOut = PCS_ALUOUT;
        PC_w              = (OPCODE == OP_BNE) ? ~Eq : Eq;
      end
      S_JUMP: begin
        M_selector_ALUOut = PCS_JUMP;
        PC_w              = 1'b1;
      end
      // EPC gets PC-4 because PC was already advanced during fetch
      S_EXC: begin
        M_selector_A      = SA_PC;
        M_selector_B      = SB_FOUR;
        ULA_c             = ULA_SUB;
        EPC_w             = 1'b1;
        M_selector_ALUOut = PCS_EXC;
        PC_w              = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - scoreboard bench for control_unit with MEM_WAIT=2 and MEM_WAIT=4 instances
module tb_control_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       reset4 = 1'b1;
  logic [5:0] OPCODE = 6'h00;
  logic [5:0] FUNCT = 6'h00;
  logic       Of = 1'b0;
  logic       Eq = 1'b0;

  logic       pc_w, mem_w, ir_w, rb_w, ab_w, alu_w, epc_w, sel_a;
  logic [2:0] ula, wd, ao, ma;
  logic [1:0] wr, sel_b;
  logic       pc_w4, mem_w4, ir_w4, rb_w4, ab_w4, alu_w4, epc_w4, sel_a4;
  logic [2:0] ula4, wd4, ao4, ma4;
  logic [1:0] wr4, sel_b4;

  control_unit #(.MEM_WAIT(2)) dut (
    .clk(clk), .reset(reset), .OPCODE(OPCODE), .FUNCT(FUNCT), .Of(Of), .Eq(Eq),
    .PC_w(pc_w), .MEM_w(mem_w), .IR_w(ir_w), .RB_w(rb_w), .AB_w(ab_w), .ALU_w(alu_w),
    .EPC_w(epc_w), .ULA_c(ula), .M_selector_writereg(wr), .M_selector_WDATA(wd),
    .M_selector_A(sel_a), .M_selector_B(sel_b), .M_selector_ALUOut(ao), .M_selector_Memory(ma)
  );

  control_unit #(.MEM_WAIT(4)) dut4 (
    .clk(clk), .reset(reset4), .OPCODE(OPCODE), .FUNCT(FUNCT), .Of(Of), .Eq(Eq),
    .PC_w(pc_w4), .MEM_w(mem_w4), .IR_w(ir_w4), .RB_w(rb_w4), .AB_w(ab_w4), .ALU_w(alu_w4),
    .EPC_w(epc_w4), .ULA_c(ula4), .M_selector_writereg(wr4), .M_selector_WDATA(wd4),
    .M_selector_A(sel_a4), .M_selector_B(sel_b4), .M_selector_ALUOut(ao4), .M_selector_Memory(ma4)
  );

  always #5 clk = ~clk;

  logic [23:0] out2, out4;
  assign out2 = {pc_w, mem_w, ir_w, rb_w, ab_w, alu_w, epc_w, ula, wr, wd, sel_a, sel_b, ao, ma};
  assign out4 = {pc_w4, mem_w4, ir_w4, rb_w4, ab_w4, alu_w4, epc_w4, ula4, wr4, wd4, sel_a4, sel_b4, ao4, ma4};

  typedef struct {
    bit          alt;
    logic [23:0] v;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  exp_t        e;
  logic [23:0] got;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      e   = q.pop_front();
      got = e.alt ? out4 : out2;
      n_vec++;
      if (got !== e.v) begin
        n_bad++;
        $display("FAIL %s: got %h required %h", e.name, got, e.v);
      end
      n_vec++;
      if ($countones({got[23], got[22], got[20]}) > 1) begin
        n_bad++;
        $display("FAIL %s_excl: PC_w/MEM_w/RB_w=%b required at most one set", e.name,
                 {got[23], got[22], got[20]});
      end
    end
  end

  function automatic logic [23:0] mk(input logic pc, input logic mw, input logic irw,
                                     input logic rbw, input logic abw, input logic aluw,
                                     input logic epcw, input logic [2:0] u, input logic [1:0] r,
                                     input logic [2:0] w, input logic a, input logic [1:0] b,
                                     input logic [2:0] o, input logic [2:0] m);
    return {pc, mw, irw, rbw, abw, aluw, epcw, u, r, w, a, b, o, m};
  endfunction

  logic [23:0] z, f_last, dec, ex_add, ex_sub, ex_and, ex_i, wb_r, wb_i;
  logic [23:0] lw_rd, lw_wb, sw_wr, br_t, br_n, jmp, exc;

  task automatic cyc(input bit alt, input logic [23:0] v, input string name);
    exp_t x;
    x.alt  = alt;
    x.v    = v;
    x.name = name;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input bit alt, input int waits, input string name);
    for (int i = 0; i < waits; i++) cyc(alt, z, $sformatf("%s_fetch%0d", name, i));
    cyc(alt, f_last, {name, "_fetch_last"});
  endtask

  task automatic instr(input logic [5:0] op, input logic [5:0] fn, input logic of_i,
                       input logic eq_i);
    OPCODE = op;
    FUNCT  = fn;
    Of     = of_i;
    Eq     = eq_i;
  endtask

  initial begin
    int n;
    z      = '0;
    f_last = mk(1, 0, 1, 0, 0, 0, 0, 3'b001, 2'b00, 3'b000, 0, 2'b01, 3'b000, 3'b000);
    dec    = mk(0, 0, 0, 0, 1, 1, 0, 3'b001, 2'b00, 3'b000, 0, 2'b11, 3'b000, 3'b000);
    ex_add = mk(0, 0, 0, 0, 0, 1, 0, 3'b001, 2'b00, 3'b000, 1, 2'b00, 3'b000, 3'b000);
    ex_sub = mk(0, 0, 0, 0, 0, 1, 0, 3'b010, 2'b00, 3'b000, 1, 2'b00, 3'b000, 3'b000);
    ex_and = mk(0, 0, 0, 0, 0, 1, 0, 3'b011, 2'b00, 3'b000, 1, 2'b00, 3'b000, 3'b000);
    ex_i   = mk(0, 0, 0, 0, 0, 1, 0, 3'b001, 2'b00, 3'b000, 1, 2'b10, 3'b000, 3'b000);
    wb_r   = mk(0, 0, 0, 1, 0, 0, 0, 3'b000, 2'b01, 3'b000, 0, 2'b00, 3'b000, 3'b000);
    wb_i   = mk(0, 0, 0, 1, 0, 0, 0, 3'b000, 2'b00, 3'b000, 0, 2'b00, 3'b000, 3'b000);
    lw_rd  = mk(0, 0, 0, 0, 0, 0, 0, 3'b000, 2'b00, 3'b000, 0, 2'b00, 3'b000, 3'b001);
    lw_wb  = mk(0, 0, 0, 1, 0, 0, 0, 3'b000, 2'b00, 3'b001, 0, 2'b00, 3'b000, 3'b001);
    sw_wr  = mk(0, 1, 0, 0, 0, 0, 0, 3'b000, 2'b00, 3'b000, 0, 2'b00, 3'b000, 3'b001);
    br_t   = mk(1, 0, 0, 0, 0, 0, 0, 3'b111, 2'b00, 3'b000, 1, 2'b00, 3'b001, 3'b000);
    br_n   = mk(0, 0, 0, 0, 0, 0, 0, 3'b111, 2'b00, 3'b000, 1, 2'b00, 3'b001, 3'b000);
    jmp    = mk(1, 0, 0, 0, 0, 0, 0, 3'b000, 2'b00, 3'b000, 0, 2'b00, 3'b010, 3'b000);
    exc    = mk(1, 0, 0, 0, 0, 0, 1, 3'b010, 2'b00, 3'b000, 0, 2'b01, 3'b100, 3'b000);

    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) cyc(0, z, $sformatf("in_reset%0d", i));
    reset = 1'b0;
    cyc(0, z, "reset_state");

    instr(6'h00, 6'h20, 0, 0);
    fetch(0, 2, "add"); cyc(0, dec, "add_dec"); cyc(0, ex_add, "add_exec"); cyc(0, wb_r, "add_wb");

    instr(6'h23, 6'h00, 0, 0);
    fetch(0, 2, "lw"); cyc(0, dec, "lw_dec"); cyc(0, ex_i, "lw_addr");
    for (int i = 0; i < 3; i++) cyc(0, lw_rd, $sformatf("lw_read%0d", i));
    cyc(0, lw_wb, "lw_wb");

    instr(6'h2B, 6'h00, 0, 0);
    fetch(0, 2, "sw"); cyc(0, dec, "sw_dec"); cyc(0, ex_i, "sw_addr"); cyc(0, sw_wr, "sw_write");

    instr(6'h04, 6'h00, 0, 1);
    fetch(0, 2, "beq_t"); cyc(0, dec, "beq_t_dec"); cyc(0, br_t, "beq_t_branch");
    instr(6'h04, 6'h00, 0, 0);
    fetch(0, 2, "beq_n"); cyc(0, dec, "beq_n_dec"); cyc(0, br_n, "beq_n_branch");
    instr(6'h05, 6'h00, 0, 1);
    fetch(0, 2, "bne_n"); cyc(0, dec, "bne_n_dec"); cyc(0, br_n, "bne_n_branch");
    instr(6'h05, 6'h00, 0, 0);
    fetch(0, 2, "bne_t"); cyc(0, dec, "bne_t_dec"); cyc(0, br_t, "bne_t_branch");

    instr(6'h08, 6'h00, 0, 0);
    fetch(0, 2, "addi"); cyc(0, dec, "addi_dec"); cyc(0, ex_i, "addi_exec"); cyc(0, wb_i, "addi_wb");

    instr(6'h02, 6'h00, 0, 0);
    fetch(0, 2, "j"); cyc(0, dec, "j_dec"); cyc(0, jmp, "j_jump");

    instr(6'h00, 6'h22, 1, 0);
    fetch(0, 2, "subov"); cyc(0, dec, "subov_dec"); cyc(0, ex_sub, "subov_exec");
    cyc(0, exc, "subov_exc");

    instr(6'h00, 6'h24, 1, 0);
    fetch(0, 2, "andov"); cyc(0, dec, "andov_dec"); cyc(0, ex_and, "andov_exec");
    cyc(0, wb_r, "andov_wb");

    instr(6'h08, 6'h00, 1, 0);
    fetch(0, 2, "addiov"); cyc(0, dec, "addiov_dec"); cyc(0, ex_i, "addiov_exec");
    cyc(0, exc, "addiov_exc");

    instr(6'h3F, 6'h00, 0, 0);
    fetch(0, 2, "badop"); cyc(0, dec, "badop_dec"); cyc(0, exc, "badop_exc");
    instr(6'h00, 6'h21, 0, 0);
    fetch(0, 2, "badfn"); cyc(0, dec, "badfn_dec"); cyc(0, exc, "badfn_exc");

    instr(6'h23, 6'h00, 0, 0);
    fetch(0, 2, "lwab"); cyc(0, dec, "lwab_dec"); cyc(0, ex_i, "lwab_addr");
    cyc(0, lw_rd, "lwab_read0");
    reset = 1'b1;
    cyc(0, lw_rd, "lwab_read1");
    reset = 1'b0;
    cyc(0, z, "lwab_reset_state");
    instr(6'h02, 6'h00, 0, 0);
    fetch(0, 2, "restart"); cyc(0, dec, "restart_dec"); cyc(0, jmp, "restart_jump");

    reset  = 1'b1;
    instr(6'h23, 6'h00, 0, 0);
    reset4 = 1'b0;
    cyc(1, z, "w4_reset_state");
    fetch(1, 4, "w4"); cyc(1, dec, "w4_dec"); cyc(1, ex_i, "w4_addr");
    for (int i = 0; i < 5; i++) cyc(1, lw_rd, $sformatf("w4_read%0d", i));
    cyc(1, lw_wb, "w4_wb");
    cyc(1, z, "w4_next_fetch");

    n = 0;
    while (q.size() > 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
